// File: rtl/pmem_seq_pkg.sv
// Shared types and default sizing for the program-memory fetch/load sequencer.
package pmem_seq_pkg;

  localparam int AW_DEF = 8;
  localparam int IW_DEF = 12;
  localparam int DEPTH  = 2 ** AW_DEF;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_RUN  = 2'd2,
    ST_HALT = 2'd3
  } state_t;

endpackage

// File: rtl/pmem_seq_pc.sv
// Program counter: clear to 0, load jump target, or +1 (wraps at AW bits); holds otherwise.
module pmem_seq_pc
  import pmem_seq_pkg::*;
#(
  parameter int AW = AW_DEF
) (
  input  logic          i_clk,
  input  logic          i_rst_n,
  input  logic          i_clr,
  input  logic          i_jmp,
  input  logic          i_inc,
  input  logic [AW-1:0] i_jmp_addr,
  output logic [AW-1:0] o_pc
);

  logic [AW-1:0] r_pc;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_pc <= '0;
    end else if (i_clr) begin
      r_pc <= '0;
    end else if (i_jmp) begin
      r_pc <= i_jmp_addr;
    end else if (i_inc) begin
      r_pc <= r_pc + AW'(1);
    end
  end

  assign o_pc = r_pc;

endmodule

// File: rtl/pmem_seq.sv
// Fetch/load sequencer for the program memory: load sessions, PC-driven fetch, halt.
// Optional macro PMEM_SEQ_BOUNDS_CHK_EN: out-of-program jumps flag err and halt instead.
module pmem_seq
  import pmem_seq_pkg::*;
#(
  parameter int AW = AW_DEF,
  parameter int IW = IW_DEF
) (
  input  logic          i_clk,
  input  logic          i_rst_n,
  input  logic          i_ld_start,
  input  logic          i_ld_valid,
  input  logic [IW-1:0] i_ld_data,
  input  logic          i_ld_last,
  output logic          o_ld_ready,
  input  logic          i_run,
  input  logic          i_halt,
  input  logic          i_stall,
  input  logic          i_jmp_en,
  input  logic [AW-1:0] i_jmp_addr,
  output logic          o_pm_le,
  output logic [AW-1:0] o_pm_la,
  output logic [IW-1:0] o_pm_li,
  output logic          o_pm_e,
  output logic [AW-1:0] o_pm_addr,
  output logic [AW-1:0] o_pc,
  output logic [1:0]    o_state,
  output logic [AW:0]   o_prog_len,
  output logic          o_err
);

  state_t        r_state, w_state_next;
  logic [AW-1:0] r_wr_cnt, w_wr_cnt_next;
  logic [AW:0]   r_prog_len, w_prog_len_next;
  logic          r_err, w_err_next;
  logic          w_pc_clr, w_pc_jmp, w_pc_inc;
  logic [AW-1:0] w_pc;
  logic          w_beat;
  logic [AW:0]   w_pc_plus1;
  logic          w_jmp_bad;

  assign w_beat     = (r_state == ST_LOAD) && i_ld_valid;
  assign w_pc_plus1 = {1'b0, w_pc} + (AW+1)'(1);

`ifdef PMEM_SEQ_BOUNDS_CHK_EN
  assign w_jmp_bad = ({1'b0, i_jmp_addr} >= r_prog_len);
`else
  assign w_jmp_bad = 1'b0;
`endif

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state    <= ST_IDLE;
      r_wr_cnt   <= '0;
      r_prog_len <= '0;
      r_err      <= 1'b0;
    end else begin
      r_state    <= w_state_next;
      r_wr_cnt   <= w_wr_cnt_next;
      r_prog_len <= w_prog_len_next;
      r_err      <= w_err_next;
    end
  end

  always_comb begin
    w_state_next    = r_state;
    w_wr_cnt_next   = r_wr_cnt;
    w_prog_len_next = r_prog_len;
    w_err_next      = r_err;
    w_pc_clr        = 1'b0;
    w_pc_jmp        = 1'b0;
    w_pc_inc        = 1'b0;
    case (r_state)
      ST_IDLE, ST_HALT: begin
        // A new load session always wins over a run request.
        if (i_ld_start) begin
          w_state_next  = ST_LOAD;
          w_wr_cnt_next = '0;
          w_err_next    = 1'b0;
        end else if (i_run && (r_prog_len != '0)) begin
          w_state_next = ST_RUN;
          w_pc_clr     = 1'b1;
        end
      end
      ST_LOAD: begin
        if (w_beat) begin
          w_wr_cnt_next = r_wr_cnt + AW'(1);
          if (i_ld_last || (&r_wr_cnt)) begin
            w_state_next    = ST_IDLE;
            w_prog_len_next = {1'b0, r_wr_cnt} + (AW+1)'(1);
            if (!i_ld_last) w_err_next = 1'b1;
          end
        end
      end
      ST_RUN: begin
        if (i_halt) begin
          w_state_next = ST_HALT;
        end else if (!i_stall) begin
          if (i_jmp_en) begin
            if (w_jmp_bad) begin
              w_err_next   = 1'b1;
              w_state_next = ST_HALT;
            end else begin
              w_pc_jmp = 1'b1;
            end
          end else if (w_pc_plus1 == r_prog_len) begin
            w_state_next = ST_HALT;
          end else begin
            w_pc_inc = 1'b1;
          end
        end
      end
      default: w_state_next = ST_IDLE;
    endcase
  end

  pmem_seq_pc #(.AW(AW)) u_pc (
    .i_clk      (i_clk),
    .i_rst_n    (i_rst_n),
    .i_clr      (w_pc_clr),
    .i_jmp      (w_pc_jmp),
    .i_inc      (w_pc_inc),
    .i_jmp_addr (i_jmp_addr),
    .o_pc       (w_pc)
  );

  // Memory-port address/data are forced to 0 whenever the port is idle.
  assign o_ld_ready = (r_state == ST_LOAD);
  assign o_pm_le    = w_beat;
  assign o_pm_la    = w_beat ? r_wr_cnt : '0;
  assign o_pm_li    = w_beat ? i_ld_data : '0;
  assign o_pm_e     = (r_state == ST_RUN);
  assign o_pm_addr  = (r_state == ST_RUN) ? w_pc : '0;
  assign o_pc       = w_pc;
  assign o_state    = r_state;
  assign o_prog_len = r_prog_len;
  assign o_err      = r_err;

endmodule

// File: tb/tb_pmem_seq.sv
// Randomized self-checking bench for pmem_seq with a behavioural sequencer model.
module tb_pmem_seq;
  import pmem_seq_pkg::*;

  localparam int AW = AW_DEF;
  localparam int IW = IW_DEF;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          ld_start, ld_valid, ld_last, ld_ready;
  logic [IW-1:0] ld_data;
  logic          run, halt, stall, jmp_en;
  logic [AW-1:0] jmp_addr;
  logic          pm_le, pm_e;
  logic [AW-1:0] pm_la, pm_addr, pc;
  logic [IW-1:0] pm_li;
  logic [1:0]    state;
  logic [AW:0]   prog_len;
  logic          err;

  int n_checks = 0;
  int n_fail   = 0;

  // Model: program length, error flag, pc and state code (0 idle,1 load,2 run,3 halt)
  int m_len   = 0;
  bit m_err   = 1'b0;
  int m_pc    = 0;
  int m_state = 0;
  logic [IW-1:0] load_words [DEPTH];

  pmem_seq dut (
    .i_clk(clk), .i_rst_n(rst_n),
    .i_ld_start(ld_start), .i_ld_valid(ld_valid), .i_ld_data(ld_data), .i_ld_last(ld_last),
    .o_ld_ready(ld_ready),
    .i_run(run), .i_halt(halt), .i_stall(stall), .i_jmp_en(jmp_en), .i_jmp_addr(jmp_addr),
    .o_pm_le(pm_le), .o_pm_la(pm_la), .o_pm_li(pm_li),
    .o_pm_e(pm_e), .o_pm_addr(pm_addr),
    .o_pc(pc), .o_state(state), .o_prog_len(prog_len), .o_err(err)
  );

  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs;
    ld_start = 0; ld_valid = 0; ld_last = 0; ld_data = '0;
    run = 0; halt = 0; stall = 0; jmp_en = 0; jmp_addr = '0;
  endtask

  task automatic test_reset;
    idle_inputs();
    rst_n = 0;
    #12;
    n_checks++;
    if ({state, pc, prog_len, err} !== {2'd0, {AW{1'b0}}, {(AW+1){1'b0}}, 1'b0}) begin
      n_fail++;
      $display("FAIL reset_regs got state=%0d pc=%0d len=%0d err=%0d want 0/0/0/0", state, pc, prog_len, err);
    end
    n_checks++;
    if ({ld_ready, pm_le, pm_e, pm_la, pm_addr, pm_li} !== '0) begin
      n_fail++;
      $display("FAIL reset_ports got rdy=%0d le=%0d e=%0d la=%0h addr=%0h li=%0h want all 0",
               ld_ready, pm_le, pm_e, pm_la, pm_addr, pm_li);
    end
    @(negedge clk);
    rst_n = 1;
    tick();
    m_len = 0; m_err = 0; m_pc = 0; m_state = 0;
    $display("reset: state=%0d pc=%0d prog_len=%0d", state, pc, prog_len);
  endtask

  // Load n words from load_words; finishes on ld_last or on the final memory slot.
  task automatic do_load(input int n, input bit with_last, input bit gaps);
    logic [AW-1:0] exp_la;
    ld_start = 1;
    run = (m_len > 0) ? 1'($urandom_range(0, 1)) : 1'b0;
    tick();
    ld_start = 0; run = 0;
    m_state = 1; m_err = 0;
    n_checks++;
    if (state !== 2'd1 || ld_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL load_enter got state=%0d rdy=%0d want 1/1", state, ld_ready);
    end
    for (int i = 0; i < n; i++) begin
      if (gaps) begin
        for (int g = 0; g < 3 && $urandom_range(0, 2) == 0; g++) begin
          ld_valid = 0; ld_start = 1'($urandom_range(0, 1)); run = 1'($urandom_range(0, 1));
          #1;
          n_checks++;
          if (pm_le !== 1'b0) begin
            n_fail++;
            $display("FAIL load_gap_le got %0d want 0", pm_le);
          end
          tick();
        end
      end
      ld_start = 0; run = 0;
      ld_valid = 1; ld_data = load_words[i]; ld_last = with_last && (i == n - 1);
      exp_la = i[AW-1:0];
      #1;
      n_checks++;
      if ({pm_le, pm_la, pm_li} !== {1'b1, exp_la, load_words[i]}) begin
        n_fail++;
        $display("FAIL load_beat[%0d] got le=%0d la=%0h li=%0h want 1/%0h/%0h",
                 i, pm_le, pm_la, pm_li, exp_la, load_words[i]);
      end
      tick();
    end
    ld_last = 0;
    m_len = n; m_state = 0;
    if (!with_last) m_err = 1;
    #1;
    n_checks++;
    if (state !== 2'd0 || prog_len !== (AW+1)'(m_len) || err !== m_err) begin
      n_fail++;
      $display("FAIL load_done got state=%0d len=%0d err=%0d want 0/%0d/%0d", state, prog_len, err, m_len, m_err);
    end
    n_checks++;
    if (ld_ready !== 1'b0 || pm_le !== 1'b0) begin
      n_fail++;
      $display("FAIL load_closed got rdy=%0d le=%0d want 0/0", ld_ready, pm_le);
    end
    ld_valid = 0;
    $display("load: %0d words last=%0d -> prog_len=%0d err=%0d", n, with_last, prog_len, err);
  endtask

  // Run from 0 with random control; jump targets stay inside the program.
  task automatic do_run(input int cycles, input int p_stall, input int p_jmp, input int p_halt);
    int steps = 0;
    run = 1;
    tick();
    run = 0; m_pc = 0; m_state = 2;
    while (m_state == 2 && steps < cycles) begin
      stall    = ($urandom_range(0, 99) < p_stall);
      jmp_en   = ($urandom_range(0, 99) < p_jmp);
      halt     = ($urandom_range(0, 99) < p_halt);
      jmp_addr = AW'($urandom_range(0, m_len - 1));
      ld_start = ($urandom_range(0, 9) == 0);
      #1;
      n_checks++;
      if ({pm_e, pm_addr, state, pc} !== {1'b1, AW'(m_pc), 2'd2, AW'(m_pc)}) begin
        n_fail++;
        $display("FAIL run_fetch got e=%0d addr=%0d state=%0d pc=%0d want 1/%0d/2/%0d",
                 pm_e, pm_addr, state, pc, m_pc, m_pc);
      end
      if (halt) m_state = 3;
      else if (stall) m_pc = m_pc;
      else if (jmp_en) m_pc = int'(jmp_addr);
      else if (m_pc + 1 == m_len) m_state = 3;
      else m_pc = m_pc + 1;
      tick();
      steps++;
    end
    idle_inputs();
    if (m_state == 2) begin
      halt = 1;
      tick();
      halt = 0;
      m_state = 3;
    end
    #1;
    n_checks++;
    if ({state, pc, pm_e, err} !== {2'd3, AW'(m_pc), 1'b0, m_err}) begin
      n_fail++;
      $display("FAIL run_end got state=%0d pc=%0d e=%0d err=%0d want 3/%0d/0/%0d", state, pc, pm_e, err, m_pc, m_err);
    end
    $display("run: %0d cycles -> halted pc=%0d", steps, pc);
  endtask

  task automatic test_load4;
    load_words[0] = 12'h101; load_words[1] = 12'h202;
    load_words[2] = 12'h303; load_words[3] = 12'h404;
    do_load(4, 1'b1, 1'b0);
  endtask

  task automatic test_run4;
    do_run(20, 0, 0, 0);
  endtask

  task automatic test_stall_jump;
    run = 1; tick(); run = 0;
    tick();
    stall = 1; tick(); tick(); stall = 0;
    n_checks++;
    if (pc !== AW'(1) || state !== 2'd2) begin
      n_fail++;
      $display("FAIL stall_hold got pc=%0d state=%0d want 1/2", pc, state);
    end
    jmp_en = 1; jmp_addr = '0; tick();
    n_checks++;
    if (pc !== AW'(0) || state !== 2'd2) begin
      n_fail++;
      $display("FAIL jump_taken got pc=%0d state=%0d want 0/2", pc, state);
    end
    tick();
    jmp_addr = AW'(2); halt = 1; tick();
    idle_inputs();
    n_checks++;
    if (pc !== AW'(0) || state !== 2'd3) begin
      n_fail++;
      $display("FAIL halt_over_jump got pc=%0d state=%0d want 0/3", pc, state);
    end
    $display("stall/jump: pc=%0d state=%0d", pc, state);
  endtask

  task automatic test_jump_oob;
    test_load4();
    run = 1; tick(); run = 0;
    jmp_en = 1; jmp_addr = AW'(9); tick();
    jmp_en = 0;
`ifdef PMEM_SEQ_BOUNDS_CHK_EN
    n_checks++;
    if ({state, pc, err} !== {2'd3, AW'(0), 1'b1}) begin
      n_fail++;
      $display("FAIL jump_oob got state=%0d pc=%0d err=%0d want 3/0/1", state, pc, err);
    end
`else
    n_checks++;
    if ({state, pc, err} !== {2'd2, AW'(9), 1'b0}) begin
      n_fail++;
      $display("FAIL jump_oob got state=%0d pc=%0d err=%0d want 2/9/0", state, pc, err);
    end
    halt = 1; tick(); halt = 0;
`endif
    $display("jump to 9 with prog_len=4: state=%0d pc=%0d err=%0d", state, pc, err);
  endtask

  task automatic test_random;
    for (int r = 0; r < 4; r++) begin
      int n = $urandom_range(1, 24);
      for (int i = 0; i < n; i++) load_words[i] = IW'($urandom);
      do_load(n, 1'b1, 1'b1);
      do_run(80, 20, 15, 3);
      do_run(40, 10, 10, 0);
    end
  endtask

  task automatic test_overflow;
    for (int i = 0; i < DEPTH; i++) load_words[i] = IW'($urandom);
    do_load(DEPTH, 1'b0, 1'b0);
    do_run(300, 5, 2, 0);
  endtask

  task automatic test_reset_midload;
    for (int i = 0; i < 2; i++) load_words[i] = IW'($urandom);
    ld_start = 1; tick(); ld_start = 0;
    ld_valid = 1;
    for (int i = 0; i < 2; i++) begin
      ld_data = load_words[i];
      tick();
    end
    @(negedge clk);
    rst_n = 0;
    #1;
    n_checks++;
    if ({state, prog_len, ld_ready, pm_le, err} !== {2'd0, {(AW+1){1'b0}}, 1'b0, 1'b0, 1'b0}) begin
      n_fail++;
      $display("FAIL midload_reset got state=%0d len=%0d rdy=%0d le=%0d err=%0d want all 0",
               state, prog_len, ld_ready, pm_le, err);
    end
    @(negedge clk);
    rst_n = 1;
    idle_inputs();
    m_len = 0;
    run = 1; tick(); run = 0; #1;
    n_checks++;
    if (state !== 2'd0 || pm_e !== 1'b0) begin
      n_fail++;
      $display("FAIL run_refused got state=%0d e=%0d want 0/0", state, pm_e);
    end
    $display("reset during load: state=%0d prog_len=%0d", state, prog_len);
  endtask

  initial begin
    test_reset();
    test_load4();
    test_run4();
    test_stall_jump();
    test_jump_oob();
    test_random();
    test_overflow();
    test_reset_midload();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
